seg7_to_bcd_scanner: RTL and testbench

SEG7_TO_BCD_SCANNER -- requirements
Module: seg7_to_bcd_scanner

---
 rtl/seg7_to_bcd_scanner.sv | 126 ++++++++++++
 tb/tb_seg7_to_bcd_scanner.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/seg7_to_bcd_scanner.sv
// seg7_to_bcd_scanner: debounces a multiplexed 7-segment display bus into a packed BCD frame.
module seg7_to_bcd_scanner #(
    parameter int DIGITS     = 4,
    parameter int SEG_WIDTH  = 7,
    parameter int BCD_WIDTH  = 4,
    parameter int STABLE_CNT = 3
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [SEG_WIDTH-1:0]        seg,
    input  logic [DIGITS-1:0]           an,
    input  logic                        in_valid,
    output logic [DIGITS*BCD_WIDTH-1:0] bcd_out,
    output logic [DIGITS-1:0]           digit_err,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic                        sel_err,
    output logic                        overrun
);
    localparam int CW = $clog2(STABLE_CNT + 1);

    typedef enum logic {EMPTY, FULL} state_t;

    state_t                      state_q, state_d;
    logic [DIGITS*BCD_WIDTH-1:0] cand_q, cand_d, buf_q, buf_d, bcd_q, bcd_d;
    logic [DIGITS-1:0]           cand_err_q, cand_err_d, buf_err_q, buf_err_d, err_q, err_d;
    logic [DIGITS-1:0]           seen_q, seen_d, commit;
    logic [DIGITS*CW-1:0]        cnt_q, cnt_d;
    logic                        sel_err_q, sel_err_d, overrun_q, overrun_d;
    logic [BCD_WIDTH-1:0]        dec_val;
    logic                        dec_err, onehot, acc, same, complete, load;
    logic [CW-1:0]               cnt_new;

    always_comb begin
        dec_err = 1'b0;
        case (seg)
            SEG_WIDTH'(7'b1111110): dec_val = BCD_WIDTH'(0);
            SEG_WIDTH'(7'b0110000): dec_val = BCD_WIDTH'(1);
            SEG_WIDTH'(7'b1101101): dec_val = BCD_WIDTH'(2);
            SEG_WIDTH'(7'b1111001): dec_val = BCD_WIDTH'(3);
            SEG_WIDTH'(7'b0110011): dec_val = BCD_WIDTH'(4);
            SEG_WIDTH'(7'b1011011): dec_val = BCD_WIDTH'(5);
            SEG_WIDTH'(7'b1011111): dec_val = BCD_WIDTH'(6);
            SEG_WIDTH'(7'b1110000): dec_val = BCD_WIDTH'(7);
            SEG_WIDTH'(7'b1111111): dec_val = BCD_WIDTH'(8);
            SEG_WIDTH'(7'b1111011): dec_val = BCD_WIDTH'(9);
            SEG_WIDTH'(7'b0000000): dec_val = BCD_WIDTH'(4'hF);
            default: begin
                dec_val = BCD_WIDTH'(4'hE);
                dec_err = 1'b1;
            end
        endcase
    end

    always_comb begin
        onehot     = (an != '0) && ((an & (an - DIGITS'(1))) == '0);
        acc        = in_valid && onehot;
        sel_err_d  = in_valid && !onehot;
        cand_d     = cand_q;
        cand_err_d = cand_err_q;
        cnt_d      = cnt_q;
        buf_d      = buf_q;
        buf_err_d  = buf_err_q;
        commit     = '0;
        same       = 1'b0;
        cnt_new    = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (acc && an[i]) begin
                same    = cand_q[i*BCD_WIDTH +: BCD_WIDTH] == dec_val && cand_err_q[i] == dec_err;
                cnt_new = !same ? CW'(1) :
                          cnt_q[i*CW +: CW] == CW'(STABLE_CNT) ? CW'(STABLE_CNT) :
                          cnt_q[i*CW +: CW] + CW'(1);
                cand_d[i*BCD_WIDTH +: BCD_WIDTH] = dec_val;
                cand_err_d[i]                    = dec_err;
                cnt_d[i*CW +: CW]                = cnt_new;
                commit[i]                        = cnt_new == CW'(STABLE_CNT);
                if (commit[i]) begin
                    buf_d[i*BCD_WIDTH +: BCD_WIDTH] = dec_val;
                    buf_err_d[i]                    = dec_err;
                end
            end
        end
        complete  = (|commit) && (&(seen_q | commit));
        seen_d    = complete ? '0 : seen_q | commit;
        // A full output only takes a new frame if the consumer drains it in the same cycle.
        load      = complete && (state_q == EMPTY || out_ready);
        overrun_d = complete && state_q == FULL && !out_ready;
        bcd_d     = load ? buf_d : bcd_q;
        err_d     = load ? buf_err_d : err_q;
        state_d   = load ? FULL : (state_q == FULL && out_ready) ? EMPTY : state_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= EMPTY;
            cand_q     <= '0;
            cand_err_q <= '0;
            cnt_q      <= '0;
            seen_q     <= '0;
            buf_q      <= '0;
            buf_err_q  <= '0;
            bcd_q      <= '0;
            err_q      <= '0;
            sel_err_q  <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cand_q     <= cand_d;
            cand_err_q <= cand_err_d;
            cnt_q      <= cnt_d;
            seen_q     <= seen_d;
            buf_q      <= buf_d;
            buf_err_q  <= buf_err_d;
            bcd_q      <= bcd_d;
            err_q      <= err_d;
            sel_err_q  <= sel_err_d;
            overrun_q  <= overrun_d;
        end
    end

    assign bcd_out   = bcd_q;
    assign digit_err = err_q;
    assign out_valid = state_q == FULL;
    assign sel_err   = sel_err_q;
    assign overrun   = overrun_q;
endmodule

// File: tb/tb_seg7_to_bcd_scanner.sv
// tb_seg7_to_bcd_scanner: directed scenario bench for the 7-segment frame scanner.
module tb_seg7_to_bcd_scanner;
    logic        clk = 1'b0, rst = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
    logic [6:0]  seg = '0;
    logic [3:0]  an = '0;
    logic [15:0] bcd_out;
    logic [3:0]  digit_err;
    logic        out_valid, sel_err, overrun;
    int          total = 0, bad = 0;

    localparam logic [6:0] S0 = 7'b1111110, S1 = 7'b0110000, S2 = 7'b1101101, S3 = 7'b1111001;
    localparam logic [6:0] S4 = 7'b0110011, S5 = 7'b1011011, S6 = 7'b1011111, S7 = 7'b1110000;
    localparam logic [6:0] S8 = 7'b1111111, S9 = 7'b1111011, SB = 7'b0000000, SX = 7'b1000000;

    seg7_to_bcd_scanner dut (
        .clk(clk), .rst(rst), .seg(seg), .an(an), .in_valid(in_valid),
        .bcd_out(bcd_out), .digit_err(digit_err), .out_valid(out_valid),
        .out_ready(out_ready), .sel_err(sel_err), .overrun(overrun)
    );

    always #5 clk = ~clk;

    task automatic smp(input logic [6:0] s, input logic [3:0] a);
        seg = s; an = a; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic idle();
        @(posedge clk); #1;
    endtask

    task automatic pulse_rst();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle();
        idle();
        rst = 1'b0;
        total++; if (bcd_out !== 16'h0) begin bad++; $display("FAIL reset_bcd got=%h exp=%h", bcd_out, 16'h0); end
        total++; if (digit_err !== 4'h0) begin bad++; $display("FAIL reset_err got=%b exp=%b", digit_err, 4'h0); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
        total++; if (sel_err !== 1'b0 || overrun !== 1'b0) begin bad++; $display("FAIL reset_pulses got=%b%b exp=00", sel_err, overrun); end
    endtask

    task automatic test_round_robin();
        logic [6:0] p [4] = '{S1, S2, S3, S4};
        out_ready = 1'b1;
        for (int r = 0; r < 3; r++)
            for (int d = 0; d < 4; d++) begin
                if (r == 2 && d == 3) begin
                    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rr_early_valid got=%b exp=0", out_valid); end
                end
                smp(p[d], 4'(1 << d));
            end
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL rr_valid got=%b exp=1", out_valid); end
        total++; if (bcd_out !== 16'h4321) begin bad++; $display("FAIL rr_bcd got=%h exp=%h", bcd_out, 16'h4321); end
        total++; if (digit_err !== 4'h0) begin bad++; $display("FAIL rr_err got=%b exp=%b", digit_err, 4'h0); end
        idle();
        total++; if (out_valid !== 1'b0 || bcd_out !== 16'h4321) begin bad++; $display("FAIL rr_drain got=%b/%h exp=0/4321", out_valid, bcd_out); end
    endtask

    task automatic test_stability();
        pulse_rst();
        for (int d = 1; d < 4; d++)
            for (int r = 0; r < 3; r++) smp(S0, 4'(1 << d));
        smp(S1, 4'b0001); smp(S1, 4'b0001); smp(S7, 4'b0001); smp(S7, 4'b0001);
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL stab_early got=%b exp=0", out_valid); end
        smp(S7, 4'b0001);
        total++; if (out_valid !== 1'b1 || bcd_out !== 16'h0007) begin bad++; $display("FAIL stab_frame got=%b/%h exp=1/0007", out_valid, bcd_out); end
    endtask

    task automatic test_bad_pattern();
        pulse_rst();
        for (int d = 0; d < 4; d++)
            for (int r = 0; r < 3; r++) smp(d == 2 ? SX : S0, 4'(1 << d));
        total++; if (bcd_out !== 16'h0E00) begin bad++; $display("FAIL badpat_bcd got=%h exp=%h", bcd_out, 16'h0E00); end
        total++; if (digit_err !== 4'b0100) begin bad++; $display("FAIL badpat_err got=%b exp=%b", digit_err, 4'b0100); end
    endtask

    task automatic test_sel_err();
        pulse_rst();
        for (int d = 1; d < 4; d++)
            for (int r = 0; r < 3; r++) smp(S0, 4'(1 << d));
        smp(S5, 4'b0001); smp(S5, 4'b0001);
        smp(S5, 4'b0011);
        total++; if (sel_err !== 1'b1 || out_valid !== 1'b0) begin bad++; $display("FAIL sel_multi got=%b/%b exp=1/0", sel_err, out_valid); end
        idle();
        total++; if (sel_err !== 1'b0) begin bad++; $display("FAIL sel_multi_clear got=%b exp=0", sel_err); end
        smp(S5, 4'b0000);
        total++; if (sel_err !== 1'b1 || out_valid !== 1'b0) begin bad++; $display("FAIL sel_zero got=%b/%b exp=1/0", sel_err, out_valid); end
        smp(S5, 4'b0001);
        total++; if (sel_err !== 1'b0 || out_valid !== 1'b1 || bcd_out !== 16'h0005) begin bad++; $display("FAIL sel_after got=%b/%b/%h exp=0/1/0005", sel_err, out_valid, bcd_out); end
    endtask

    task automatic test_back_to_back();
        logic [6:0] a [4] = '{S1, S2, S3, S4};
        logic [6:0] b [4] = '{S5, S6, S7, S8};
        pulse_rst();
        out_ready = 1'b1;
        for (int r = 0; r < 3; r++)
            for (int d = 0; d < 4; d++) smp(a[d], 4'(1 << d));
        out_ready = 1'b0;
        for (int d = 0; d < 4; d++)
            for (int r = 0; r < 3; r++) smp(b[d], 4'(1 << d));
        total++; if (overrun !== 1'b1) begin bad++; $display("FAIL ovr_pulse got=%b exp=1", overrun); end
        total++; if (bcd_out !== 16'h4321 || out_valid !== 1'b1) begin bad++; $display("FAIL ovr_hold got=%h/%b exp=4321/1", bcd_out, out_valid); end
        idle();
        total++; if (overrun !== 1'b0) begin bad++; $display("FAIL ovr_clear got=%b exp=0", overrun); end
        smp(S5, 4'b0001); smp(S6, 4'b0010); smp(S7, 4'b0100);
        total++; if (bcd_out !== 16'h4321) begin bad++; $display("FAIL b2b_hold got=%h exp=%h", bcd_out, 16'h4321); end
        out_ready = 1'b1;
        smp(S8, 4'b1000);
        total++; if (out_valid !== 1'b1 || bcd_out !== 16'h8765 || overrun !== 1'b0) begin bad++; $display("FAIL b2b_load got=%b/%h/%b exp=1/8765/0", out_valid, bcd_out, overrun); end
    endtask

    task automatic test_reset_mid();
        logic [6:0] p [4] = '{S9, S9, S9, SB};
        smp(S5, 4'b0001); smp(S6, 4'b0010);
        pulse_rst();
        total++; if (bcd_out !== 16'h0 || digit_err !== 4'h0 || out_valid !== 1'b0) begin bad++; $display("FAIL midrst got=%h/%b/%b exp=0000/0000/0", bcd_out, digit_err, out_valid); end
        for (int r = 0; r < 2; r++)
            for (int d = 0; d < 4; d++) smp(p[d], 4'(1 << d));
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL midrst_early got=%b exp=0", out_valid); end
        for (int d = 0; d < 4; d++) smp(p[d], 4'(1 << d));
        total++; if (out_valid !== 1'b1 || bcd_out !== 16'hF999 || digit_err !== 4'h0) begin bad++; $display("FAIL midrst_frame got=%b/%h/%b exp=1/f999/0000", out_valid, bcd_out, digit_err); end
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_stability();
        test_bad_pattern();
        test_sel_err();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
